// File: rtl/morse_char_queue_if.sv
// Signal bundle between the key source, the character queue and the
// buzzer side. The queue itself connects through the slave modport;
// whatever drives keys and busy (top level or a bench) uses master.
interface morse_char_queue_if #(
    parameter int DEPTH = 8
);
    // Key source side
    logic [4:0]             key_code;
    logic                   key_valid;
    // Buzzer side
    logic                   buzzer_busy;
    logic [4:0]             char_out;
    logic                   start_out;
    // Queue status
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic                   code_err;

    modport master (
        output key_code,
        output key_valid,
        output buzzer_busy,
        input  char_out,
        input  start_out,
        input  count,
        input  full,
        input  empty,
        input  overflow,
        input  code_err
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  buzzer_busy,
        output char_out,
        output start_out,
        output count,
        output full,
        output empty,
        output overflow,
        output code_err
    );
endinterface

// File: rtl/morse_char_queue.sv
// Morse character queue: buffers key codes from the button front end in a
// small FIFO and hands them to the encoder/buzzer one at a time. Each
// character gets a one-cycle start pulse, then the dispatcher waits for
// busy to rise and fall (or gives up waiting for the rise) and enforces a
// silent gap before the next character is launched.
module morse_char_queue #(
    parameter int DEPTH        = 8,        // power of two, 2..32
    parameter int GAP_CYCLES   = 2500000,  // >= 1
    parameter int BUSY_TIMEOUT = 4,        // >= 1
    parameter int MAX_CODE     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    morse_char_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    // One extra bit so MAX_CODE values up to 63 compare without truncation.
    localparam logic [5:0]       CODE_MAX = 6'(MAX_CODE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // Storage: plain array, no reset, so it can map onto RAM. Flushing on
    // reset is done by clearing pointers and count, not the contents.
    logic [4:0] mem [DEPTH];

    // FIFO bookkeeping state
    logic             key_valid_q, key_valid_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             overflow_q,  overflow_d;
    logic             code_err_q,  code_err_d;

    // Dispatcher state
    state_t           state_q,     state_d;
    logic [4:0]       char_q,      char_d;
    logic             start_q,     start_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;

    // Decoded push/pop events for this cycle
    logic push_edge;
    logic code_bad;
    logic empty_w;
    logic full_w;
    logic pop;
    logic push_ok;
    logic push_lost;

    // Classify this cycle's key activity and decide what the FIFO does.
    always_comb begin
        push_edge = bus.key_valid & ~key_valid_q;
        code_bad  = ({1'b0, bus.key_code} > CODE_MAX);
        empty_w   = (count_q == '0);
        full_w    = (count_q == CNT_FULL);
        // The dispatcher takes an entry only from IDLE.
        pop       = (state_q == ST_IDLE) & ~empty_w;
        // A pop in the same cycle frees the slot, so a push into a full
        // FIFO still succeeds when the dispatcher is draining it.
        push_ok   = push_edge & ~code_bad & (~full_w | pop);
        push_lost = push_edge & ~code_bad & full_w & ~pop;
    end

    // Next-state for pointers, occupancy and the status flags.
    always_comb begin
        key_valid_d = bus.key_valid;
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d  = overflow_q | push_lost;
        code_err_d  = push_edge & code_bad;
    end

    // Dispatcher next-state: launch, wait for busy, wait for idle, gap.
    always_comb begin
        state_d   = state_q;
        char_d    = char_q;
        start_d   = 1'b0;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty_w) begin
                    char_d  = mem[rd_ptr_q];
                    start_d = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.buzzer_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    // Busy never showed up; treat the character as done
                    // rather than hang the queue.
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.buzzer_busy) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                // A late busy freezes the gap so silence is measured only
                // while the buzzer is actually quiet.
                if (!bus.buzzer_busy) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage write; read-before-write keeps a full push+pop safe
    // because the dispatcher samples the old entry in the same cycle.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.key_code;
        end
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            code_err_q  <= code_err_d;
        end
    end

    // Dispatcher registers, including the registered char/start outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            char_q    <= '0;
            start_q   <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            char_q    <= char_d;
            start_q   <= start_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign bus.char_out  = char_q;
    assign bus.start_out = start_q;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == CNT_FULL);
    assign bus.empty     = (count_q == '0);
    assign bus.overflow  = overflow_q;
    assign bus.code_err  = code_err_q;

endmodule

// File: tb/tb_morse_char_queue.sv
// Bench for morse_char_queue. Stimulus pushes the expected dispatch order
// into a scoreboard queue; a monitor thread pops it on every start pulse
// and also checks the spacing between consecutive pulses when armed.
// A buzzer model produces busy in one of three modes.
module tb_morse_char_queue;
    localparam int DEPTH    = 4;
    localparam int GAP      = 8;
    localparam int TIMEOUT  = 4;
    localparam int BUSY_LEN = 20;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    morse_char_queue_if #(.DEPTH(DEPTH)) bus ();

    morse_char_queue #(
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP),
        .BUSY_TIMEOUT(TIMEOUT),
        .MAX_CODE    (11)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int sb[$];
    int busy_mode   = 1;   // 0: pulse after start, 1: tied low, 2: stuck high
    int spacing_exp = 0;   // 0 disables the start-to-start spacing check
    bit have_last   = 1'b0;
    int last_cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int code, input bit expect_out);
        @(negedge clk);
        bus.key_code  = 5'(code);
        bus.key_valid = 1'b1;
        if (expect_out) sb.push_back(code);
        @(negedge clk);
        bus.key_valid = 1'b0;
        $display("[TB] push code=%0d count=%0d cycle=%0d", code, bus.count, cyc);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !bus.empty) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n < 3000), 1);
        repeat (45) @(negedge clk);
    endtask

    // Buzzer model: in mode 0 busy is high for BUSY_LEN cycles starting
    // one cycle after each start pulse.
    task automatic busy_loop();
        int busy_left = 0;
        forever begin
            @(negedge clk);
            if (busy_mode != 0) begin
                busy_left       = 0;
                bus.buzzer_busy = (busy_mode == 2);
            end else begin
                if (busy_left > 0) begin
                    bus.buzzer_busy = 1'b1;
                    busy_left--;
                end else begin
                    bus.buzzer_busy = 1'b0;
                end
                if (bus.start_out) busy_left = BUSY_LEN;
            end
        end
    endtask

    // Scoreboard monitor: every start pulse must match the next expected code.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (bus.start_out) begin
                $display("[TB] start char=%0d cycle=%0d", bus.char_out, cyc);
                if (sb.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    check("char_out", int'(bus.char_out), sb.pop_front());
                end
                if (spacing_exp != 0 && have_last) begin
                    check("start_spacing", cyc - last_cyc, spacing_exp);
                end
                have_last = 1'b1;
                last_cyc  = cyc;
            end
        end
    endtask

    task automatic run_stim();
        // Reset values
        rst_n = 1'b0;
        bus.key_code  = '0;
        bus.key_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_char",     int'(bus.char_out),  0);
        check("rst_start",    int'(bus.start_out), 0);
        check("rst_count",    int'(bus.count),     0);
        check("rst_empty",    int'(bus.empty),     1);
        check("rst_full",     int'(bus.full),      0);
        check("rst_overflow", int'(bus.overflow),  0);
        check("rst_code_err", int'(bus.code_err),  0);
        rst_n = 1'b1;

        // 1: single push, start pulses the cycle after count becomes 1
        busy_mode = 0;
        repeat (6) @(negedge clk);
        push(5, 1'b1);
        check("t1_count", int'(bus.count), 1);
        check("t1_empty", int'(bus.empty), 0);
        @(negedge clk);
        check("t1_start", int'(bus.start_out), 1);
        check("t1_char",  int'(bus.char_out),  5);
        @(negedge clk);
        check("t1_start_fall", int'(bus.start_out), 0);
        drain();

        // 2: burst while busy; spacing = 1 + 1 + BUSY_LEN + GAP + 1
        spacing_exp = 31;
        have_last   = 1'b0;
        push(1, 1'b1);
        repeat (3) @(negedge clk);
        push(2, 1'b1);
        repeat (2) @(negedge clk);
        push(3, 1'b1);
        drain();
        spacing_exp = 0;

        // 3: overflow with busy stuck high
        busy_mode = 2;
        push(6, 1'b1);
        push(7, 1'b1);
        push(8, 1'b1);
        push(9, 1'b1);
        push(10, 1'b1);
        check("t3_count_full", int'(bus.count),    4);
        check("t3_full",       int'(bus.full),     1);
        check("t3_no_ovf_yet", int'(bus.overflow), 0);
        push(11, 1'b0);
        check("t3_overflow",   int'(bus.overflow), 1);
        check("t3_count_held", int'(bus.count),    4);
        busy_mode = 0;
        drain();
        check("t3_ovf_sticky", int'(bus.overflow), 1);

        // 4: level held high gives one push; bad code gives one code_err
        @(negedge clk);
        bus.key_code  = 5'd3;
        bus.key_valid = 1'b1;
        sb.push_back(3);
        @(negedge clk);
        check("t4_count_one", int'(bus.count), 1);
        repeat (99) @(negedge clk);
        bus.key_valid = 1'b0;
        drain();
        push(15, 1'b0);
        check("t4_code_err", int'(bus.code_err), 1);
        check("t4_bad_count", int'(bus.count), 0);
        @(negedge clk);
        check("t4_code_err_fall", int'(bus.code_err), 0);
        check("t4_empty", int'(bus.empty), 1);

        // 5: busy never rises; spacing = 1 + TIMEOUT + GAP + 1
        busy_mode   = 1;
        spacing_exp = 14;
        have_last   = 1'b0;
        push(4, 1'b1);
        push(9, 1'b1);
        drain();
        spacing_exp = 0;

        // 6: async reset with 3 entries queued while waiting for busy to fall
        busy_mode = 0;
        push(1, 1'b1);
        push(2, 1'b0);
        push(3, 1'b0);
        push(4, 1'b0);
        check("t6_queued", int'(bus.count), 3);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        busy_mode = 1;
        #1;
        check("t6_rst_char",     int'(bus.char_out),  0);
        check("t6_rst_start",    int'(bus.start_out), 0);
        check("t6_rst_count",    int'(bus.count),     0);
        check("t6_rst_empty",    int'(bus.empty),     1);
        check("t6_rst_overflow", int'(bus.overflow),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_still_empty", int'(bus.empty), 1);
        check("t6_sb_empty", sb.size(), 0);
    endtask

    initial begin
        bus.buzzer_busy = 1'b0;
        fork
            run_stim();
            monitor_loop();
            busy_loop();
            begin
                repeat (20000) @(posedge clk);
                check("watchdog", 1, 0);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
